// File: rtl/lc3_ctrl_fsm_if.sv
// Control/status bundle between the LC-3 control FSM and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface lc3_ctrl_fsm_if;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic        addr_sel;
  logic        ld_ir;
  logic        ld_pc;
  logic        ld_r7;
  logic        ld_reg;
  logic        ld_cc;
  logic        ld_mar;
  logic        ld_mdr;
  logic [1:0]  pc_sel;
  logic [1:0]  reg_src;
  logic        mar_src;
  logic [3:0]  state_o;
  logic        instr_done;
  logic        err_illegal;
  logic        err_timeout;

  modport master (
    input  ir, nzp, mem_ack,
    output mem_req, mem_we, addr_sel, ld_ir, ld_pc, ld_r7, ld_reg, ld_cc,
           ld_mar, ld_mdr, pc_sel, reg_src, mar_src, state_o,
           instr_done, err_illegal, err_timeout
  );

  modport slave (
    output ir, nzp, mem_ack,
    input  mem_req, mem_we, addr_sel, ld_ir, ld_pc, ld_r7, ld_reg, ld_cc,
           ld_mar, ld_mdr, pc_sel, reg_src, mar_src, state_o,
           instr_done, err_illegal, err_timeout
  );
endinterface

// File: rtl/lc3_ctrl_fsm.sv
// LC-3 multicycle control FSM: fetch/decode/execute sequencing with
// memory wait states guarded by a timeout counter.
module lc3_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  lc3_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_ADDR   = 4'd3,
    S_IND    = 4'd4,
    S_RD     = 4'd5,
    S_WR     = 4'd6,
    S_WB     = 4'd7,
    S_CTL    = 4'd8
  } state_t;

  localparam int CW = (MEM_TIMEOUT > 16) ? $clog2(MEM_TIMEOUT) : 4;
  localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          hold_reg, hold_next;

  // One-hot opcode decode of ir[15:12].
  logic [15:0] op_hot;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_op
      assign op_hot[gi] = (bus.ir[15:12] == 4'(gi));
    end
  endgenerate

  logic op_alu, op_lea, op_mem, op_ctl, op_ind, op_rd, op_wr;
  logic op_br, op_jsr, op_jmp;
  assign op_lea = op_hot[14];
  assign op_alu = op_hot[1] | op_hot[5] | op_hot[9] | op_lea;
  assign op_ind = op_hot[10] | op_hot[11];
  assign op_rd  = op_hot[2] | op_hot[6];
  assign op_wr  = op_hot[3] | op_hot[7];
  assign op_mem = op_ind | op_rd | op_wr;
  assign op_br  = op_hot[0];
  assign op_jsr = op_hot[4];
  assign op_jmp = op_hot[12];
  assign op_ctl = op_br | op_jsr | op_jmp;

  logic br_taken;
  assign br_taken = (bus.ir[11] & bus.nzp[2]) | (bus.ir[10] & bus.nzp[1]) |
                    (bus.ir[9] & bus.nzp[0]);

  // FETCH right after a timeout is a dead cycle with mem_req low.
  logic wait_state, acked, timeout;
  assign wait_state = ((state_reg == S_FETCH) & ~hold_reg) | (state_reg == S_IND) |
                      (state_reg == S_RD) | (state_reg == S_WR);
  assign acked      = wait_state & bus.mem_ack;
  assign timeout    = wait_state & ~bus.mem_ack & (cnt_reg == CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_FETCH;
      cnt_reg   <= '0;
      hold_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH: begin
        if (acked) state_next = S_DECODE;
      end
      S_DECODE: begin
        if (op_alu)      state_next = S_EXEC;
        else if (op_mem) state_next = S_ADDR;
        else if (op_ctl) state_next = S_CTL;
        else             state_next = S_FETCH;
      end
      S_ADDR: begin
        if (op_ind)     state_next = S_IND;
        else if (op_rd) state_next = S_RD;
        else if (op_wr) state_next = S_WR;
        else            state_next = S_FETCH;
      end
      S_IND: begin
        if (acked)        state_next = op_hot[11] ? S_WR : S_RD;
        else if (timeout) state_next = S_FETCH;
      end
      S_RD: begin
        if (acked)        state_next = S_WB;
        else if (timeout) state_next = S_FETCH;
      end
      S_WR: begin
        if (acked | timeout) state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase

    hold_next = timeout;
    // Counter restarts on every state change, ack or timeout.
    if ((state_next != state_reg) || acked || timeout || !wait_state)
      cnt_next = '0;
    else
      cnt_next = cnt_reg + 1'b1;
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.mem_we      = 1'b0;
    bus.addr_sel    = 1'b0;
    bus.ld_ir       = 1'b0;
    bus.ld_pc       = 1'b0;
    bus.ld_r7       = 1'b0;
    bus.ld_reg      = 1'b0;
    bus.ld_cc       = 1'b0;
    bus.ld_mar      = 1'b0;
    bus.ld_mdr      = 1'b0;
    bus.pc_sel      = 2'd0;
    bus.reg_src     = 2'd0;
    bus.mar_src     = 1'b0;
    bus.instr_done  = 1'b0;
    bus.err_illegal = 1'b0;
    bus.err_timeout = 1'b0;
    bus.state_o     = 4'd0;
    if (!rst) begin
      bus.state_o     = state_reg;
      bus.err_timeout = timeout;
      case (state_reg)
        S_FETCH: begin
          if (!hold_reg) begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
              bus.ld_ir = 1'b1;
              bus.ld_pc = 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (!(op_alu | op_mem | op_ctl)) begin
            bus.err_illegal = 1'b1;
            bus.instr_done  = 1'b1;
          end
        end
        S_EXEC: begin
          bus.ld_reg     = 1'b1;
          bus.ld_cc      = 1'b1;
          bus.reg_src    = op_lea ? 2'd2 : 2'd0;
          bus.instr_done = 1'b1;
        end
        S_ADDR: bus.ld_mar = 1'b1;
        S_IND: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          if (bus.mem_ack) begin
            bus.ld_mar  = 1'b1;
            bus.mar_src = 1'b1;
          end
        end
        S_RD: begin
          bus.mem_req  = 1'b1;
          bus.addr_sel = 1'b1;
          bus.ld_mdr   = bus.mem_ack;
        end
        S_WB: begin
          bus.ld_reg     = 1'b1;
          bus.ld_cc      = 1'b1;
          bus.reg_src    = 2'd1;
          bus.instr_done = 1'b1;
        end
        S_WR: begin
          bus.mem_req    = 1'b1;
          bus.mem_we     = 1'b1;
          bus.addr_sel   = 1'b1;
          bus.instr_done = bus.mem_ack;
        end
        S_CTL: begin
          bus.instr_done = op_ctl;
          if (op_br && br_taken) begin
            bus.ld_pc  = 1'b1;
            bus.pc_sel = 2'd1;
          end else if (op_jmp) begin
            bus.ld_pc  = 1'b1;
            bus.pc_sel = 2'd3;
          end else if (op_jsr) begin
            bus.ld_r7  = 1'b1;
            bus.ld_pc  = 1'b1;
            bus.pc_sel = bus.ir[11] ? 2'd2 : 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm: per-cycle state and control-word checks
// against hand-derived expectations.
module tb_lc3_ctrl_fsm;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  lc3_ctrl_fsm_if bus ();

  lc3_ctrl_fsm #(.MEM_TIMEOUT(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word bit layout for compact expectations.
  localparam logic [17:0] REQ  = 18'h20000;
  localparam logic [17:0] WE   = 18'h10000;
  localparam logic [17:0] ASEL = 18'h08000;
  localparam logic [17:0] LIR  = 18'h04000;
  localparam logic [17:0] LPC  = 18'h02000;
  localparam logic [17:0] LR7  = 18'h01000;
  localparam logic [17:0] LREG = 18'h00800;
  localparam logic [17:0] LCC  = 18'h00400;
  localparam logic [17:0] LMAR = 18'h00200;
  localparam logic [17:0] LMDR = 18'h00100;
  localparam logic [17:0] PC1  = 18'h00040;
  localparam logic [17:0] PC2  = 18'h00080;
  localparam logic [17:0] PC3  = 18'h000C0;
  localparam logic [17:0] RS1  = 18'h00010;
  localparam logic [17:0] RS2  = 18'h00020;
  localparam logic [17:0] MSRC = 18'h00008;
  localparam logic [17:0] DONE = 18'h00004;
  localparam logic [17:0] ILL  = 18'h00002;
  localparam logic [17:0] TMO  = 18'h00001;
  localparam logic [17:0] FETCH_ACK = REQ | LIR | LPC;

  function automatic logic [17:0] cw_now();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ld_ir, bus.ld_pc, bus.ld_r7,
            bus.ld_reg, bus.ld_cc, bus.ld_mar, bus.ld_mdr, bus.pc_sel, bus.reg_src,
            bus.mar_src, bus.instr_done, bus.err_illegal, bus.err_timeout};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Inputs are set just after a rising edge; check, then advance one cycle.
  task automatic cyc(input string tag, input logic [3:0] es, input logic [17:0] ecw);
    #1;
    chk({tag, ".state"}, 32'(bus.state_o), 32'(es));
    chk({tag, ".ctrl"}, 32'(cw_now()), 32'(ecw));
    $display("cycle %s: state=%0d ctrl=%h (exp %0d/%h)", tag, bus.state_o, cw_now(), es, ecw);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    bus.ir      = 16'h1261;
    bus.nzp     = 3'b000;
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 4'd0, 18'h0);

    // ADD R1,R1,#1 with immediate acks.
    rst = 1'b0;
    cyc("add.fetch", 4'd0, FETCH_ACK);
    cyc("add.decode", 4'd1, 18'h0);
    cyc("add.exec", 4'd2, LREG | LCC | DONE);

    // LEA selects the effective-address write source.
    bus.ir = 16'hE000;
    cyc("lea.fetch", 4'd0, FETCH_ACK);
    cyc("lea.decode", 4'd1, 18'h0);
    cyc("lea.exec", 4'd2, LREG | LCC | RS2 | DONE);

    // LDI with two-cycle ack delay in each wait state.
    bus.ir = 16'hA402;
    bus.mem_ack = 1'b0;
    cyc("ldi.fetch.w0", 4'd0, REQ);
    cyc("ldi.fetch.w1", 4'd0, REQ);
    bus.mem_ack = 1'b1;
    cyc("ldi.fetch.ack", 4'd0, FETCH_ACK);
    bus.mem_ack = 1'b0;
    cyc("ldi.decode", 4'd1, 18'h0);
    bus.mem_ack = 1'b1;
    cyc("ldi.addr", 4'd3, LMAR);
    bus.mem_ack = 1'b0;
    cyc("ldi.ind.w0", 4'd4, REQ | ASEL);
    cyc("ldi.ind.w1", 4'd4, REQ | ASEL);
    bus.mem_ack = 1'b1;
    cyc("ldi.ind.ack", 4'd4, REQ | ASEL | LMAR | MSRC);
    bus.mem_ack = 1'b0;
    cyc("ldi.rd.w0", 4'd5, REQ | ASEL);
    cyc("ldi.rd.w1", 4'd5, REQ | ASEL);
    bus.mem_ack = 1'b1;
    cyc("ldi.rd.ack", 4'd5, REQ | ASEL | LMDR);
    cyc("ldi.wb", 4'd7, LREG | LCC | RS1 | DONE);

    // BRnp: not taken on Z, taken on P.
    bus.ir  = 16'h0A05;
    bus.nzp = 3'b010;
    cyc("brnt.fetch", 4'd0, FETCH_ACK);
    cyc("brnt.decode", 4'd1, 18'h0);
    cyc("brnt.ctl", 4'd8, DONE);
    bus.nzp = 3'b001;
    cyc("brt.fetch", 4'd0, FETCH_ACK);
    cyc("brt.decode", 4'd1, 18'h0);
    cyc("brt.ctl", 4'd8, LPC | PC1 | DONE);

    // JSR (PC-relative), JSRR (BaseR), JMP.
    bus.ir = 16'h4800;
    cyc("jsr.fetch", 4'd0, FETCH_ACK);
    cyc("jsr.decode", 4'd1, 18'h0);
    cyc("jsr.ctl", 4'd8, LR7 | LPC | PC2 | DONE);
    bus.ir = 16'h41C0;
    cyc("jsrr.fetch", 4'd0, FETCH_ACK);
    cyc("jsrr.decode", 4'd1, 18'h0);
    cyc("jsrr.ctl", 4'd8, LR7 | LPC | PC3 | DONE);
    bus.ir = 16'hC1C0;
    cyc("jmp.fetch", 4'd0, FETCH_ACK);
    cyc("jmp.decode", 4'd1, 18'h0);
    cyc("jmp.ctl", 4'd8, LPC | PC3 | DONE);

    // ST: four cycles with immediate ack.
    bus.ir = 16'h3000;
    cyc("st.fetch", 4'd0, FETCH_ACK);
    cyc("st.decode", 4'd1, 18'h0);
    cyc("st.addr", 4'd3, LMAR);
    cyc("st.wr", 4'd6, REQ | WE | ASEL | DONE);

    // STI with no ack in WR: timeout after 15 request cycles.
    bus.ir = 16'hB605;
    cyc("sti.fetch", 4'd0, FETCH_ACK);
    cyc("sti.decode", 4'd1, 18'h0);
    cyc("sti.addr", 4'd3, LMAR);
    cyc("sti.ind", 4'd4, REQ | ASEL | LMAR | MSRC);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) cyc($sformatf("sti.wr.w%0d", i), 4'd6, REQ | WE | ASEL);
    cyc("sti.wr.tmo", 4'd6, REQ | WE | ASEL | TMO);
    bus.mem_ack = 1'b1;
    cyc("sti.dead", 4'd0, 18'h0);
    bus.mem_ack = 1'b0;
    cyc("sti.refetch.w0", 4'd0, REQ);

    // Same STI, ack on the final allowed cycle: no error.
    bus.mem_ack = 1'b1;
    cyc("sti2.fetch", 4'd0, FETCH_ACK);
    cyc("sti2.decode", 4'd1, 18'h0);
    cyc("sti2.addr", 4'd3, LMAR);
    cyc("sti2.ind", 4'd4, REQ | ASEL | LMAR | MSRC);
    bus.mem_ack = 1'b0;
    for (int i = 0; i < 14; i++) cyc($sformatf("sti2.wr.w%0d", i), 4'd6, REQ | WE | ASEL);
    bus.mem_ack = 1'b1;
    cyc("sti2.wr.ack", 4'd6, REQ | WE | ASEL | DONE);

    // Reserved opcode.
    bus.ir = 16'hD000;
    cyc("ill.fetch", 4'd0, FETCH_ACK);
    cyc("ill.decode", 4'd1, ILL | DONE);

    // LD interrupted by reset in the second RD cycle.
    bus.ir = 16'h2000;
    cyc("ld.fetch", 4'd0, FETCH_ACK);
    cyc("ld.decode", 4'd1, 18'h0);
    cyc("ld.addr", 4'd3, LMAR);
    bus.mem_ack = 1'b0;
    cyc("ld.rd.w0", 4'd5, REQ | ASEL);
    rst = 1'b1;
    bus.mem_ack = 1'b1;
    cyc("ld.rd.rst", 4'd0, 18'h0);
    rst = 1'b0;
    bus.mem_ack = 1'b0;
    cyc("after.rst", 4'd0, REQ);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc3_ctrl_fsm.md
LC3_CTRL_FSM -- requirements
Module: lc3_ctrl_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15: maximum cycles any memory wait state holds mem_req without mem_ack.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 ir  in  16  instruction register contents from the datapath, valid from DECODE onward.
REQ-005 nzp  in  3  condition codes {N,Z,P} from the datapath.
REQ-006 mem_ack  in  1  memory completes the pending access this cycle; read data is valid this cycle.
REQ-007 mem_req, mem_we  out  1 each  memory request; write qualifier.
REQ-008 addr_sel  out  1  memory address source: 0=PC, 1=MAR.
REQ-009 ld_ir, ld_pc, ld_r7, ld_reg, ld_cc, ld_mar, ld_mdr  out  1 each  datapath register load enables.
REQ-010 pc_sel  out  2  next-PC source: 0=PC+1, 1=PC+SEXT(ir[8:0]), 2=PC+SEXT(ir[10:0]), 3=BaseR ir[8:6].
REQ-011 reg_src  out  2  DR write source: 0=ALU, 1=MDR, 2=effective address (LEA).
REQ-012 mar_src  out  1  MAR source: 0=effective address, 1=MDR (indirect).
REQ-013 state_o  out  4  current state encoding; instr_done, err_illegal, err_timeout  out  1 each  single-cycle pulses.

Function
REQ-014 States and encodings: FETCH=0, DECODE=1, EXEC=2, ADDR=3, IND=4, RD=5, WR=6, WB=7, CTL=8; other codes are unreachable, and an unreachable code SHALL decode to FETCH on the next cycle.
REQ-015 Outputs SHALL be combinational from state, ir, nzp, and mem_ack, and SHALL be 0 unless listed as asserted in that state.
REQ-016 FETCH: mem_req=1, addr_sel=0; on mem_ack, ld_ir=1 and ld_pc=1 with pc_sel=0, then go to DECODE.
REQ-017 DECODE: one cycle; ir[15:12] selects the next state.
REQ-017a ADD(0001), AND(0101), NOT(1001), LEA(1110) go to EXEC.
REQ-017b LD(0010), ST(0011), LDR(0110), STR(0111), LDI(1010), STI(1011) go to ADDR.
REQ-017c BR(0000), JSR(0100), JMP(1100) go to CTL.
REQ-017d RTI(1000), reserved(1101), TRAP(1111) pulse err_illegal and instr_done, then go to FETCH.
REQ-018 EXEC: ld_reg=1 and ld_cc=1; reg_src=2 for LEA, otherwise 0; pulse instr_done; go to FETCH.
REQ-019 ADDR: ld_mar=1, mar_src=0; LDI/STI go to IND, LD/LDR go to RD, ST/STR go to WR.
REQ-020 IND: mem_req=1, addr_sel=1, mem_we=0; on mem_ack, ld_mar=1 with mar_src=1; LDI then goes to RD, STI to WR.
REQ-021 RD: mem_req=1, addr_sel=1; on mem_ack, ld_mdr=1 and go to WB.
REQ-021a WB: ld_reg=1, reg_src=1, ld_cc=1; pulse instr_done; go to FETCH.
REQ-022 WR: mem_req=1, mem_we=1, addr_sel=1; on mem_ack, pulse instr_done and go to FETCH.
REQ-023 CTL, BR: the branch is taken iff (ir[11]&nzp[2]) | (ir[10]&nzp[1]) | (ir[9]&nzp[0]); if taken, ld_pc=1 with pc_sel=1.
REQ-023a CTL, JMP: ld_pc=1, pc_sel=3.
REQ-023b CTL, JSR: ld_r7=1, and ld_pc=1 with pc_sel=2 if ir[11]=1, else pc_sel=3.
REQ-023c CTL: all three pulse instr_done and go to FETCH.
REQ-024 JSR with ld_r7 and ld_pc in the same cycle: the datapath SHALL use pre-edge PC and BaseR values, so JSRR R7 jumps to the old R7.
REQ-025 mem_req and mem_we SHALL remain stable while waiting; mem_ack when mem_req=0 SHALL be ignored.
REQ-026 Latencies with mem_ack in the first request cycle: ALU/LEA 3 cycles, BR/JMP/JSR 3, LD/LDR 5, ST/STR 4, LDI 6, STI 5.
REQ-027 A 4-bit-or-wider wait counter SHALL clear on entry to each wait state (FETCH, IND, RD, WR) and increment each cycle mem_req is held without mem_ack.
REQ-027a Timeout: when the counter equals MEM_TIMEOUT-1 with no mem_ack, pulse err_timeout, deassert mem_req next cycle, and go to FETCH with no register loads; PC is not advanced.
REQ-028 mem_ack in the same cycle as timeout: the ack wins; no err_timeout.

Reset
REQ-029 While rst=1: state goes to FETCH, the wait counter clears, and all outputs are forced to 0, including mem_req.
REQ-030 The first cycle after rst falls SHALL assert mem_req with addr_sel=0; rst in any state, including mid-access, SHALL abandon the access with no load enables asserted.

Verification
REQ-031 Reset, then ack every request immediately; ir=0x1261 (ADD R1,R1,#1) -> state_o 0,1,2,0; ld_reg and ld_cc in cycle 3; instr_done once.
REQ-032 ir=0xA402 (LDI R2); ack delayed 2 cycles in each wait state -> states FETCH,DECODE,ADDR,IND,RD,WB; ld_mar with mar_src=1 at the IND ack; ld_reg with reg_src=1 in WB.
REQ-033 ir=0x0A05 (BRnp); nzp=010 -> no ld_pc in CTL; nzp=001 -> ld_pc=1 with pc_sel=1.
REQ-034 ir=0xB605 (STI); mem_ack never asserted in WR -> err_timeout pulse after MEM_TIMEOUT cycles, mem_req=0, state_o=0; repeat with ack on the final cycle -> no error.
REQ-035 ir=0xD000 -> err_illegal and instr_done in DECODE, then FETCH; rst asserted in RD cycle 2 -> mem_req=0 and state_o=0 next cycle.
